// File: rtl/multi_debouncer_pkg.sv
// Shared helpers for the multi-channel debouncer: counter width sizing and parameter legality.
package multi_debouncer_pkg;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Divider and qualification lengths must be at least one.
  function automatic bit param_ok(input int v);
    return v >= 1;
  endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Input/output bundle of the multi-channel debouncer: raw inputs, debounced levels and strobes.
interface multi_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] din;
  logic [N_CH-1:0] db_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            tick;

  modport master (output din, input db_out, input rise, input fall, input tick);
  modport slave  (input din, output db_out, output rise, output fall, output tick);
endinterface

// File: rtl/debounce_tick_gen.sv
// Shared sample-tick divider: one-cycle strobe every TICK_DIV clocks.
module debounce_tick_gen
  import multi_debouncer_pkg::*;
#(
  parameter int TICK_DIV = 5000
) (
  input  logic clk,
  input  logic rst_a_p,
  output logic tick
);

  localparam int unsigned CW = clog2_min1(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  if (!param_ok(TICK_DIV)) begin : g_bad_div
    $error("debounce_tick_gen: TICK_DIV must be >= 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Registered strobe mirrors the cycle in which the counter sits at LAST.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// N-channel button/switch debouncer: 2-flop synchronizer, shared sample tick,
// per-channel stability counter with registered level and rise/fall pulses.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 5000,
  parameter int STABLE_CNT = 4,
  parameter bit INIT_VAL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_a_p,
  multi_debouncer_if.slave   bus
);

  localparam int unsigned SW = clog2_min1(STABLE_CNT);
  localparam logic [SW-1:0] TERM = SW'(STABLE_CNT - 1);

  if (!param_ok(STABLE_CNT)) begin : g_bad_stable
    $error("multi_debouncer: STABLE_CNT must be >= 1");
  end

  logic            tick_w;
  logic [N_CH-1:0] meta_q;
  logic [N_CH-1:0] sync_q;
  logic [N_CH-1:0] db_q;
  logic [N_CH-1:0] rise_q;
  logic [N_CH-1:0] fall_q;

  debounce_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_a_p (rst_a_p),
    .tick    (tick_w)
  );

  // Synchronizer resets to INIT_VAL so a matching input at release is not seen as an edge.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      meta_q <= {N_CH{INIT_VAL}};
      sync_q <= {N_CH{INIT_VAL}};
    end else begin
      meta_q <= bus.din;
      sync_q <= meta_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;
    logic          flip_c;
    logic          db_r;
    logic          rise_r;
    logic          fall_r;

    // Any agreeing tick restarts qualification; the terminal disagreeing tick flips the level.
    always_comb begin
      cnt_d  = cnt_q;
      flip_c = 1'b0;
      if (tick_w) begin
        if (sync_q[i] == db_r) begin
          cnt_d = '0;
        end else if (cnt_q == TERM) begin
          cnt_d  = '0;
          flip_c = 1'b1;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
        cnt_q  <= '0;
        db_r   <= INIT_VAL;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        rise_r <= flip_c & sync_q[i];
        fall_r <= flip_c & ~sync_q[i];
        if (flip_c) begin
          db_r <= sync_q[i];
        end
      end
    end

    assign db_q[i]   = db_r;
    assign rise_q[i] = rise_r;
    assign fall_q[i] = fall_r;
  end

  assign bus.db_out = db_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  assign bus.tick   = tick_w;

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: expected pulse events are queued as stimulus is
// driven and matched against pulse events captured from the outputs.
module tb_multi_debouncer;

  typedef struct {
    int       cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] db;
  } obs_t;

  typedef struct {
    int       cmin;
    int       cmax;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] db;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic rst_c;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  obs_t obs_a[$];
  obs_t obs_b[$];
  obs_t obs_c[$];
  exp_t exp_a[$];
  exp_t exp_b[$];

  multi_debouncer_if #(.N_CH(4)) if_a ();
  multi_debouncer_if #(.N_CH(4)) if_b ();
  multi_debouncer_if #(.N_CH(4)) if_c ();

  multi_debouncer #(.N_CH(4), .TICK_DIV(4), .STABLE_CNT(3), .INIT_VAL(1'b0)) dut_a (
    .clk(clk), .rst_a_p(rst_a), .bus(if_a.slave));
  multi_debouncer #(.N_CH(4), .TICK_DIV(1), .STABLE_CNT(1), .INIT_VAL(1'b0)) dut_b (
    .clk(clk), .rst_a_p(rst_b), .bus(if_b.slave));
  multi_debouncer #(.N_CH(4), .TICK_DIV(4), .STABLE_CNT(3), .INIT_VAL(1'b1)) dut_c (
    .clk(clk), .rst_a_p(rst_c), .bus(if_c.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon_a
    obs_t o;
    if ((if_a.rise | if_a.fall) != 4'b0000) begin
      o.cyc = cyc; o.rise = if_a.rise; o.fall = if_a.fall; o.db = if_a.db_out;
      obs_a.push_back(o);
    end
  end

  always @(negedge clk) begin : mon_b
    obs_t o;
    if ((if_b.rise | if_b.fall) != 4'b0000) begin
      o.cyc = cyc; o.rise = if_b.rise; o.fall = if_b.fall; o.db = if_b.db_out;
      obs_b.push_back(o);
    end
  end

  always @(negedge clk) begin : mon_c
    obs_t o;
    if ((if_c.rise | if_c.fall) != 4'b0000) begin
      o.cyc = cyc; o.rise = if_c.rise; o.fall = if_c.fall; o.db = if_c.db_out;
      obs_c.push_back(o);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (if_a.db_out !== 4'b0000 || if_a.rise !== 4'b0000 || if_a.fall !== 4'b0000 || if_a.tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_a: db=%b rise=%b fall=%b tick=%b, need 0000 0000 0000 0",
               if_a.db_out, if_a.rise, if_a.fall, if_a.tick);
    end
    total++;
    if (if_c.db_out !== 4'b1111 || if_b.tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: db_c=%b tick_b=%b, need 1111 0", if_c.db_out, if_b.tick);
    end
    step(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    step(2);
  endtask

  task automatic test_clean_press();
    exp_t e;
    obs_t o;
    int   c0;
    step(1);
    if_a.din = 4'b0001;
    c0 = cyc;
    e.cmin = c0 + 11; e.cmax = c0 + 14; e.rise = 4'b0001; e.fall = 4'b0000; e.db = 4'b0001;
    exp_a.push_back(e);
    step(30);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        bad++;
        $display("FAIL press_pulse: no pulse seen, need rise=%b fall=%b", e.rise, e.fall);
      end else begin
        o = obs_a.pop_front();
        if (o.cyc < e.cmin || o.cyc > e.cmax || o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db) begin
          bad++;
          $display("FAIL press_pulse: got cyc=%0d rise=%b fall=%b db=%b, need cyc %0d..%0d rise=%b fall=%b db=%b",
                   o.cyc, o.rise, o.fall, o.db, e.cmin, e.cmax, e.rise, e.fall, e.db);
        end
      end
    end
    total++;
    if (obs_a.size() != 0) begin
      bad++;
      $display("FAIL press_extra: got %0d extra pulse cycles, need 0", obs_a.size());
    end
    obs_a.delete();
    total++;
    if (if_a.db_out !== 4'b0001 || if_a.rise !== 4'b0000) begin
      bad++;
      $display("FAIL press_level: db=%b rise=%b, need 0001 0000", if_a.db_out, if_a.rise);
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    obs_t o;
    int   c_last = 0;
    for (int k = 0; k < 13; k++) begin
      step(1);
      total++;
      if (if_a.db_out[1] !== 1'b0) begin
        bad++;
        $display("FAIL bounce_hold: db[1]=%b at toggle %0d, need 0", if_a.db_out[1], k);
      end
      if_a.din[1] = ~if_a.din[1];
      c_last = cyc;
      step(4);
    end
    e.cmin = c_last + 11; e.cmax = c_last + 14; e.rise = 4'b0010; e.fall = 4'b0000; e.db = 4'b0011;
    exp_a.push_back(e);
    step(26);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        bad++;
        $display("FAIL bounce_pulse: no pulse seen, need rise=%b fall=%b", e.rise, e.fall);
      end else begin
        o = obs_a.pop_front();
        if (o.cyc < e.cmin || o.cyc > e.cmax || o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db) begin
          bad++;
          $display("FAIL bounce_pulse: got cyc=%0d rise=%b fall=%b db=%b, need cyc %0d..%0d rise=%b fall=%b db=%b",
                   o.cyc, o.rise, o.fall, o.db, e.cmin, e.cmax, e.rise, e.fall, e.db);
        end
      end
    end
    total++;
    if (obs_a.size() != 0) begin
      bad++;
      $display("FAIL bounce_extra: got %0d extra pulse cycles, need 0", obs_a.size());
    end
    obs_a.delete();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    obs_t o;
    int   c0;
    step(1);
    if_a.din = 4'b1000;
    c0 = cyc;
    e.cmin = c0 + 11; e.cmax = c0 + 14; e.rise = 4'b1000; e.fall = 4'b0011; e.db = 4'b1000;
    exp_a.push_back(e);
    step(30);
    if_a.din = 4'b0100;
    c0 = cyc;
    e.cmin = c0 + 11; e.cmax = c0 + 14; e.rise = 4'b0100; e.fall = 4'b1000; e.db = 4'b0100;
    exp_a.push_back(e);
    step(30);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        bad++;
        $display("FAIL simul_pulse: no pulse seen, need rise=%b fall=%b", e.rise, e.fall);
      end else begin
        o = obs_a.pop_front();
        if (o.cyc < e.cmin || o.cyc > e.cmax || o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db) begin
          bad++;
          $display("FAIL simul_pulse: got cyc=%0d rise=%b fall=%b db=%b, need cyc %0d..%0d rise=%b fall=%b db=%b",
                   o.cyc, o.rise, o.fall, o.db, e.cmin, e.cmax, e.rise, e.fall, e.db);
        end
      end
    end
    total++;
    if (obs_a.size() != 0) begin
      bad++;
      $display("FAIL simul_extra: got %0d extra pulse cycles, need 0", obs_a.size());
    end
    obs_a.delete();
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    obs_t o;
    int   c0;
    int   r;
    step(1);
    if_a.din = 4'b0000;
    c0 = cyc;
    e.cmin = c0 + 11; e.cmax = c0 + 14; e.rise = 4'b0000; e.fall = 4'b0100; e.db = 4'b0000;
    exp_a.push_back(e);
    step(30);
    if_a.din = 4'b0001;
    step(9);
    rst_a = 1'b1;
    #1;
    total++;
    if (if_a.db_out !== 4'b0000 || if_a.rise !== 4'b0000 || if_a.fall !== 4'b0000 || if_a.tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: db=%b rise=%b fall=%b tick=%b, need 0000 0000 0000 0",
               if_a.db_out, if_a.rise, if_a.fall, if_a.tick);
    end
    step(1);
    rst_a = 1'b0;
    r = cyc;
    // Divider restarts at release: ticks in cycles r+3, r+7, r+11, sync valid from r+2.
    e.cmin = r + 12; e.cmax = r + 12; e.rise = 4'b0001; e.fall = 4'b0000; e.db = 4'b0001;
    exp_a.push_back(e);
    step(30);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        bad++;
        $display("FAIL mid_pulse: no pulse seen, need rise=%b fall=%b", e.rise, e.fall);
      end else begin
        o = obs_a.pop_front();
        if (o.cyc < e.cmin || o.cyc > e.cmax || o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db) begin
          bad++;
          $display("FAIL mid_pulse: got cyc=%0d rise=%b fall=%b db=%b, need cyc %0d..%0d rise=%b fall=%b db=%b",
                   o.cyc, o.rise, o.fall, o.db, e.cmin, e.cmax, e.rise, e.fall, e.db);
        end
      end
    end
    total++;
    if (obs_a.size() != 0) begin
      bad++;
      $display("FAIL mid_extra: got %0d extra pulse cycles, need 0", obs_a.size());
    end
    obs_a.delete();
  endtask

  task automatic test_degenerate();
    exp_t       e;
    obs_t       o;
    logic [3:0] prev;
    logic [3:0] nd;
    prev = 4'b0000;
    for (int k = 0; k < 40; k++) begin
      step(1);
      total++;
      if (if_b.tick !== 1'b1) begin
        bad++;
        $display("FAIL degen_tick: tick=%b at step %0d, need 1", if_b.tick, k);
      end
      nd = 4'($urandom);
      if_b.din = nd;
      if (nd != prev) begin
        e.cmin = cyc + 3; e.cmax = cyc + 3; e.rise = nd & ~prev; e.fall = prev & ~nd; e.db = nd;
        exp_b.push_back(e);
      end
      prev = nd;
    end
    step(10);
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      total++;
      if (obs_b.size() == 0) begin
        bad++;
        $display("FAIL degen_pulse: no pulse seen, need rise=%b fall=%b", e.rise, e.fall);
      end else begin
        o = obs_b.pop_front();
        if (o.cyc != e.cmin || o.rise !== e.rise || o.fall !== e.fall || o.db !== e.db) begin
          bad++;
          $display("FAIL degen_pulse: got cyc=%0d rise=%b fall=%b db=%b, need cyc %0d rise=%b fall=%b db=%b",
                   o.cyc, o.rise, o.fall, o.db, e.cmin, e.rise, e.fall, e.db);
        end
      end
    end
    total++;
    if (obs_b.size() != 0) begin
      bad++;
      $display("FAIL degen_extra: got %0d extra pulse cycles, need 0", obs_b.size());
    end
    obs_b.delete();
  endtask

  task automatic test_init_high();
    int errs = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (if_c.db_out !== 4'b1111 || if_c.rise !== 4'b0000 || if_c.fall !== 4'b0000) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL init_high_level: %0d cycles off, need db=1111 with no pulses", errs);
    end
    total++;
    if (obs_c.size() != 0) begin
      bad++;
      $display("FAIL init_high_pulse: got %0d pulse cycles since reset, need 0", obs_c.size());
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    if_a.din = 4'b0000;
    if_b.din = 4'b0000;
    if_c.din = 4'b1111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_degenerate();
    test_init_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
